// File: rtl/mem_port_arbiter.sv
// Two-client cache-line memory arbiter: merges the I-side read port and the D-side
// read/write port onto one external master port, one transaction at a time, round-robin.
module mem_port_arbiter #(
   parameter int XLEN      = 32,
   parameter int CLSIZE    = 128,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 I_strobe_i,
   input  logic [XLEN-1:0]      I_addr_i,
   output logic                 I_done_o,
   output logic [CLSIZE-1:0]    I_data_o,
   input  logic                 D_strobe_i,
   input  logic [XLEN-1:0]      D_addr_i,
   input  logic                 D_rw_i,
   input  logic [CLSIZE-1:0]    D_data_i,
   output logic                 D_done_o,
   output logic [CLSIZE-1:0]    D_data_o,
   output logic                 M_strobe_o,
   output logic [XLEN-1:0]      M_addr_o,
   output logic                 M_rw_o,
   output logic [CLSIZE-1:0]    M_data_o,
   input  logic                 M_done_i,
   input  logic [CLSIZE-1:0]    M_data_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] i_txn_cnt_o,
   output logic [CNT_WIDTH-1:0] d_txn_cnt_o
);

   localparam int OFF = $clog2(CLSIZE / 8);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << OFF) - 1);

   typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP, RELEASE} state_t;

   state_t                state_q, state_d;
   logic                  last_d_q;
   logic                  gnt_d_q;
   logic                  rw_q;
   logic                  m_strobe_q;
   logic                  i_done_q;
   logic                  d_done_q;
   logic                  busy_q;
   logic [CNT_WIDTH-1:0]  i_cnt_q;
   logic [CNT_WIDTH-1:0]  d_cnt_q;
   logic [XLEN-1:0]       addr_q;
   logic [CLSIZE-1:0]     wdata_q;
   logic [CLSIZE-1:0]     rdata_q;
   logic                  take;
   logic                  grant_d;
   logic                  serving;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie the client that was not served last wins
            if (I_strobe_i && D_strobe_i) begin
               take    = 1'b1;
               grant_d = ~last_d_q;
            end else if (I_strobe_i) begin
               take    = 1'b1;
               grant_d = 1'b0;
            end else if (D_strobe_i) begin
               take    = 1'b1;
               grant_d = 1'b1;
            end
            if (take) state_d = grant_d ? SERVE_D : SERVE_I;
         end
         SERVE_I, SERVE_D: if (M_done_i) state_d = RESP;
         RESP:             state_d = RELEASE;
         RELEASE:          state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         last_d_q   <= 1'b0;
         gnt_d_q    <= 1'b0;
         rw_q       <= 1'b0;
         m_strobe_q <= 1'b0;
         i_done_q   <= 1'b0;
         d_done_q   <= 1'b0;
         busy_q     <= 1'b0;
         i_cnt_q    <= '0;
         d_cnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         m_strobe_q <= (state_d == SERVE_I) || (state_d == SERVE_D);
         i_done_q   <= (state_d == RESP) && !gnt_d_q;
         d_done_q   <= (state_d == RESP) &&  gnt_d_q;
         busy_q     <= (state_d != IDLE);
         if (take) begin
            gnt_d_q <= grant_d;
            rw_q    <= grant_d & D_rw_i;
         end
         if (state_q == RESP) begin
            last_d_q <= gnt_d_q;
            if (gnt_d_q) d_cnt_q <= sat_inc(d_cnt_q);
            else         i_cnt_q <= sat_inc(i_cnt_q);
         end
      end
   end

   // Request/response line storage; outputs are gated by the control flops
   always_ff @(posedge clk_i) begin
      if (take) begin
         addr_q  <= (grant_d ? D_addr_i : I_addr_i) & ALIGN_MASK;
         wdata_q <= (grant_d && D_rw_i) ? D_data_i : '0;
      end
      if (serving && M_done_i) rdata_q <= M_data_i;
   end

   assign M_strobe_o  = m_strobe_q;
   assign M_addr_o    = m_strobe_q ? addr_q : '0;
   assign M_rw_o      = m_strobe_q & rw_q;
   assign M_data_o    = (m_strobe_q && rw_q) ? wdata_q : '0;
   assign I_done_o    = i_done_q;
   assign D_done_o    = d_done_q;
   assign I_data_o    = i_done_q ? rdata_q : '0;
   assign D_data_o    = (d_done_q && !rw_q) ? rdata_q : '0;
   assign busy_o      = busy_q;
   assign i_txn_cnt_o = i_cnt_q;
   assign d_txn_cnt_o = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model with a bench-driven external memory.
module tb_mem_port_arbiter;

   localparam int XLEN      = 32;
   localparam int CLSIZE    = 128;
   localparam int CNT_WIDTH = 4;
   localparam int CMAX      = (1 << CNT_WIDTH) - 1;
   localparam logic [XLEN-1:0] AMASK = ~XLEN'(CLSIZE / 8 - 1);

   typedef logic [CLSIZE-1:0] line_t;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b1;
   logic                 I_strobe_i = 1'b0;
   logic [XLEN-1:0]      I_addr_i = '0;
   logic                 I_done_o;
   line_t                I_data_o;
   logic                 D_strobe_i = 1'b0;
   logic [XLEN-1:0]      D_addr_i = '0;
   logic                 D_rw_i = 1'b0;
   line_t                D_data_i = '0;
   logic                 D_done_o;
   line_t                D_data_o;
   logic                 M_strobe_o;
   logic [XLEN-1:0]      M_addr_o;
   logic                 M_rw_o;
   line_t                M_data_o;
   logic                 M_done_i = 1'b0;
   line_t                M_data_i = '0;
   logic                 busy_o;
   logic [CNT_WIDTH-1:0] i_txn_cnt_o;
   logic [CNT_WIDTH-1:0] d_txn_cnt_o;

   mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .I_strobe_i(I_strobe_i), .I_addr_i(I_addr_i), .I_done_o(I_done_o), .I_data_o(I_data_o),
      .D_strobe_i(D_strobe_i), .D_addr_i(D_addr_i), .D_rw_i(D_rw_i), .D_data_i(D_data_i),
      .D_done_o(D_done_o), .D_data_o(D_data_o),
      .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
      .M_done_i(M_done_i), .M_data_i(M_data_i),
      .busy_o(busy_o), .i_txn_cnt_o(i_txn_cnt_o), .d_txn_cnt_o(d_txn_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   // Reference model: pending requests, who was served last, completed counts
   bit pend_i, pend_d, last_d, late_en;
   int exp_ci, exp_cd;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic line_t rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input line_t obs, input line_t exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mstb"}, line_t'(M_strobe_o), '0);
      chk({tag, "_busy"}, line_t'(busy_o), '0);
      chk({tag, "_idone"}, line_t'(I_done_o), '0);
      chk({tag, "_ddone"}, line_t'(D_done_o), '0);
      chk({tag, "_idata"}, I_data_o, '0);
      chk({tag, "_ddata"}, D_data_o, '0);
      chk({tag, "_maddr"}, line_t'(M_addr_o), '0);
      chk({tag, "_mrw"}, line_t'(M_rw_o), '0);
      chk({tag, "_mdata"}, M_data_o, '0);
      chk({tag, "_icnt"}, line_t'(i_txn_cnt_o), '0);
      chk({tag, "_dcnt"}, line_t'(d_txn_cnt_o), '0);
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      I_strobe_i = 1'b0; D_strobe_i = 1'b0; M_done_i = 1'b0;
      pend_i = 0; pend_d = 0;
      @(negedge clk_i);
      check_all_zero("rst");
      step();
      rst_ni = 1'b1;
      last_d = 0; exp_ci = 0; exp_cd = 0;
   endtask

   task automatic rand_fields();
      if (!pend_i) I_addr_i = $urandom;
      if (!pend_d) begin
         D_addr_i = $urandom;
         D_rw_i   = 1'($urandom);
         D_data_i = rnd_line();
      end
   endtask

   // One arbitrated transaction; entered and left in an IDLE cycle just after a clock edge.
   task automatic txn(input bit raise_i, input bit raise_d, input int lat,
                      input line_t rdata, input bit keep_high);
      bit              win_d;
      logic [XLEN-1:0] ea;
      bit              ew;
      line_t           ed;
      if (raise_i) begin pend_i = 1; I_strobe_i = 1'b1; end
      if (raise_d) begin pend_d = 1; D_strobe_i = 1'b1; end
      if (!pend_i && !pend_d) return;
      win_d = pend_d && !(pend_i && last_d);
      ea = (win_d ? D_addr_i : I_addr_i) & AMASK;
      ew = win_d && D_rw_i;
      ed = ew ? D_data_i : '0;
      @(negedge clk_i);
      chk("idle_busy", line_t'(busy_o), '0);
      chk("idle_mstb", line_t'(M_strobe_o), '0);
      step();
      // Requester inputs of the winner may now change freely
      if ($urandom_range(0, 1) == 1) begin
         if (win_d) begin
            D_addr_i = $urandom; D_rw_i = 1'($urandom); D_data_i = rnd_line();
            if ($urandom_range(0, 3) == 0) D_strobe_i = 1'b0;
         end else begin
            I_addr_i = $urandom;
            if ($urandom_range(0, 3) == 0) I_strobe_i = 1'b0;
         end
      end
      if (late_en && $urandom_range(0, 2) == 0) begin
         if (win_d && !pend_i) begin
            I_addr_i = $urandom; I_strobe_i = 1'b1; pend_i = 1;
         end else if (!win_d && !pend_d) begin
            D_addr_i = $urandom; D_rw_i = 1'($urandom); D_data_i = rnd_line();
            D_strobe_i = 1'b1; pend_d = 1;
         end
      end
      for (int k = 0; k <= lat; k++) begin
         if (k == lat) begin M_done_i = 1'b1; M_data_i = rdata; end
         @(negedge clk_i);
         chk("srv_mstb", line_t'(M_strobe_o), line_t'(1'b1));
         chk("srv_addr", line_t'(M_addr_o), line_t'(ea));
         chk("srv_rw", line_t'(M_rw_o), line_t'(ew));
         chk("srv_data", M_data_o, ed);
         chk("srv_busy", line_t'(busy_o), line_t'(1'b1));
         chk("srv_idone", line_t'(I_done_o), '0);
         chk("srv_ddone", line_t'(D_done_o), '0);
         step();
      end
      M_done_i = 1'($urandom);
      M_data_i = rnd_line();
      @(negedge clk_i);
      chk("resp_idone", line_t'(I_done_o), line_t'(!win_d));
      chk("resp_ddone", line_t'(D_done_o), line_t'(win_d));
      chk("resp_idata", I_data_o, win_d ? line_t'(0) : rdata);
      chk("resp_ddata", D_data_o, (win_d && !ew) ? rdata : line_t'(0));
      chk("resp_mstb", line_t'(M_strobe_o), '0);
      if (win_d) begin
         if (exp_cd < CMAX) exp_cd++;
         pend_d = 0;
      end else begin
         if (exp_ci < CMAX) exp_ci++;
         pend_i = 0;
      end
      last_d = win_d;
      step();
      M_done_i = 1'($urandom);
      if (!keep_high) begin
         if (win_d) D_strobe_i = 1'b0; else I_strobe_i = 1'b0;
      end
      @(negedge clk_i);
      chk("rel_idone", line_t'(I_done_o), '0);
      chk("rel_ddone", line_t'(D_done_o), '0);
      chk("rel_busy", line_t'(busy_o), line_t'(1'b1));
      chk("rel_icnt", line_t'(i_txn_cnt_o), line_t'(exp_ci));
      chk("rel_dcnt", line_t'(d_txn_cnt_o), line_t'(exp_cd));
      step();
      M_done_i = 1'b0;
      if (win_d) D_strobe_i = 1'b0; else I_strobe_i = 1'b0;
      if (keep_high && !pend_i && !pend_d) begin
         repeat (2) begin
            @(negedge clk_i);
            chk("kh_busy", line_t'(busy_o), '0);
            step();
         end
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 4 && (pend_i || pend_d); g++)
         txn(1'b0, 1'b0, $urandom_range(0, 2), rnd_line(), 1'b0);
   endtask

   initial begin
      late_en = 0;
      #1;
      apply_reset();

      // I read, memory answers after five strobe cycles
      I_addr_i = 32'h8000_0004;
      txn(1'b1, 1'b0, 4, {4{32'hAAAA_AAAA}}, 1'b0);
      chk("i1_icnt", line_t'(i_txn_cnt_o), line_t'(1));
      chk("i1_dcnt", line_t'(d_txn_cnt_o), '0);

      // D write
      D_addr_i = 32'h8000_1010; D_rw_i = 1'b1;
      D_data_i = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_5678;
      txn(1'b0, 1'b1, 2, rnd_line(), 1'b0);
      chk("d1_dcnt", line_t'(d_txn_cnt_o), line_t'(1));

      // Tie right after reset: D first, then I, twice
      apply_reset();
      I_addr_i = 32'h0000_1234; D_addr_i = 32'h0000_5678; D_rw_i = 1'b0;
      txn(1'b1, 1'b1, 1, rnd_line(), 1'b0);
      chk("tie1_dcnt", line_t'(d_txn_cnt_o), line_t'(1));
      chk("tie1_icnt", line_t'(i_txn_cnt_o), '0);
      txn(1'b0, 1'b0, 0, rnd_line(), 1'b0);
      chk("tie2_icnt", line_t'(i_txn_cnt_o), line_t'(1));
      rand_fields();
      txn(1'b1, 1'b1, 2, rnd_line(), 1'b0);
      chk("tie3_dcnt", line_t'(d_txn_cnt_o), line_t'(2));
      chk("tie3_icnt", line_t'(i_txn_cnt_o), line_t'(1));
      txn(1'b0, 1'b0, 1, rnd_line(), 1'b0);
      chk("tie4_icnt", line_t'(i_txn_cnt_o), line_t'(2));

      // Strobe kept high through RELEASE must not be re-granted
      rand_fields();
      txn(1'b1, 1'b0, 1, rnd_line(), 1'b1);
      chk("kh_icnt", line_t'(i_txn_cnt_o), line_t'(3));

      // M_done_i while idle is ignored
      M_done_i = 1'b1; M_data_i = rnd_line();
      step();
      M_done_i = 1'b0;
      repeat (2) begin
         @(negedge clk_i);
         chk("stray_busy", line_t'(busy_o), '0);
         chk("stray_idone", line_t'(I_done_o), '0);
         chk("stray_ddone", line_t'(D_done_o), '0);
         step();
      end

      // Reset asserted while serving D
      D_addr_i = 32'h8000_2000; D_rw_i = 1'b0; D_strobe_i = 1'b1;
      step();
      @(negedge clk_i);
      chk("mid_mstb_pre", line_t'(M_strobe_o), line_t'(1'b1));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_mstb", line_t'(M_strobe_o), '0);
      chk("mid_busy", line_t'(busy_o), '0);
      chk("mid_icnt", line_t'(i_txn_cnt_o), '0);
      chk("mid_dcnt", line_t'(d_txn_cnt_o), '0);
      D_strobe_i = 1'b0;
      step();
      rst_ni = 1'b1;
      pend_i = 0; pend_d = 0; last_d = 0; exp_ci = 0; exp_cd = 0;
      M_done_i = 1'b1; M_data_i = rnd_line();
      repeat (6) begin
         @(negedge clk_i);
         chk("mid_ddone", line_t'(D_done_o), '0);
         chk("mid_busy2", line_t'(busy_o), '0);
         step();
         M_done_i = 1'b0;
      end

      // Counter saturation at CNT_WIDTH=4
      for (int t = 0; t < 17; t++) begin
         rand_fields();
         txn(1'b1, 1'b0, $urandom_range(0, 2), rnd_line(), 1'b0);
      end
      chk("sat_icnt", line_t'(i_txn_cnt_o), line_t'(CMAX));
      chk("sat_dcnt", line_t'(d_txn_cnt_o), '0);

      // Randomized traffic, including requests arriving mid-transaction
      apply_reset();
      late_en = 1;
      for (int t = 0; t < 40; t++) begin
         rand_fields();
         txn(1'($urandom), 1'($urandom), $urandom_range(0, 3), rnd_line(), 1'($urandom));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
